// File: rtl/exc_flush_ctrl_if.sv
// exc_flush_ctrl_if: bundles the WB request, CSR and IF redirect signals
// of the exception/flush controller.
// master modport: the controller side. slave modport: the pipeline/CSR side.
interface exc_flush_ctrl_if;
    // WB stage requests
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_csr_pc;
    logic [31:0] wb_wrong_addr;
    logic        ertn_flush;
    logic        int_req;
    logic [31:0] int_pc;
    // CSR file values used as redirect targets
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    // CSR commit record
    logic        ex_commit;
    logic [5:0]  ex_ecode;
    logic [8:0]  ex_esubcode;
    logic [31:0] ex_era;
    logic [31:0] ex_badv;
    logic        ertn_commit;
    // pipeline control and IF redirect handshake
    logic [3:0]  flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;

    modport master (
        input  wb_ex, wb_ecode, wb_esubcode, wb_csr_pc, wb_wrong_addr,
        input  ertn_flush, int_req, int_pc, csr_eentry, csr_era, redirect_ready,
        output ex_commit, ex_ecode, ex_esubcode, ex_era, ex_badv, ertn_commit,
        output flush, redirect_valid, redirect_pc, busy
    );

    modport slave (
        output wb_ex, wb_ecode, wb_esubcode, wb_csr_pc, wb_wrong_addr,
        output ertn_flush, int_req, int_pc, csr_eentry, csr_era, redirect_ready,
        input  ex_commit, ex_ecode, ex_esubcode, ex_era, ex_badv, ertn_commit,
        input  flush, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/exc_flush_ctrl.sv
// exc_flush_ctrl: pipeline recovery sequencer for exceptions, interrupts
// and ERTN taken at WB. Latches the exception record, pulses the CSR
// commit, holds flush for DRAIN_CYCLES, then hands the redirect PC to IF.
// Optional build macro EXC_FLUSH_CTRL_PERF_EN adds three saturating
// performance counters as extra outputs.
module exc_flush_ctrl #(
    parameter int DRAIN_CYCLES = 2      // legal range 0..15
) (
    input  logic                 clk,
    input  logic                 reset,
    exc_flush_ctrl_if.master     bus
`ifdef EXC_FLUSH_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_ex_cnt,
    output logic [31:0]          perf_ertn_cnt,
    output logic [31:0]          perf_busy_cyc
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    // Counter load value on leaving COMMIT; unused when there is no drain window.
    localparam logic [3:0] DRAIN_INIT = (DRAIN_CYCLES == 0) ? 4'd0 : 4'(DRAIN_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [3:0]  drain_cnt_reg, drain_cnt_next;
    logic        take_ex, take_int, take_ertn;
    logic        enter_redirect;

    logic        kind_ertn_reg;
    logic [5:0]  ecode_reg;
    logic [8:0]  esubcode_reg;
    logic [31:0] era_reg;
    logic [31:0] badv_reg;
    logic [31:0] redirect_pc_reg;

    // State and drain counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            drain_cnt_reg <= 4'd0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    // Next-state logic; requests are only accepted in IDLE, others belong
    // to instructions already being squashed.
    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        take_ex        = 1'b0;
        take_int       = 1'b0;
        take_ertn      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.wb_ex) begin
                    take_ex = 1'b1;
                end else if (bus.int_req) begin
                    take_int = 1'b1;
                end else if (bus.ertn_flush) begin
                    take_ertn = 1'b1;
                end
                if (bus.wb_ex || bus.int_req || bus.ertn_flush) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (DRAIN_CYCLES == 0) begin
                    state_next = ST_REDIRECT;
                end else begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = DRAIN_INIT;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_reg == 4'd0) begin
                    state_next = ST_REDIRECT;
                end else begin
                    drain_cnt_next = drain_cnt_reg - 4'd1;
                end
            end
            ST_REDIRECT: begin
                if (bus.redirect_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The redirect target is captured on the edge that enters REDIRECT, so
    // the CSR write performed during COMMIT is already visible.
    assign enter_redirect = (state_next == ST_REDIRECT) && (state_reg != ST_REDIRECT);

    // Exception record and redirect target latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kind_ertn_reg   <= 1'b0;
            ecode_reg       <= 6'd0;
            esubcode_reg    <= 9'd0;
            era_reg         <= 32'd0;
            badv_reg        <= 32'd0;
            redirect_pc_reg <= 32'd0;
        end else begin
            if (take_ex) begin
                kind_ertn_reg <= 1'b0;
                ecode_reg     <= bus.wb_ecode;
                esubcode_reg  <= bus.wb_esubcode;
                era_reg       <= bus.wb_csr_pc;
                badv_reg      <= bus.wb_wrong_addr;
            end else if (take_int) begin
                // Interrupts carry no bad address; BADV keeps its old value.
                kind_ertn_reg <= 1'b0;
                ecode_reg     <= 6'h00;
                esubcode_reg  <= 9'd0;
                era_reg       <= bus.int_pc;
            end else if (take_ertn) begin
                kind_ertn_reg <= 1'b1;
            end
            if (enter_redirect) begin
                redirect_pc_reg <= kind_ertn_reg ? bus.csr_era : bus.csr_eentry;
            end
        end
    end

    // All outputs are decoded from state or taken from registers.
    assign bus.ex_commit      = (state_reg == ST_COMMIT) && !kind_ertn_reg;
    assign bus.ertn_commit    = (state_reg == ST_COMMIT) &&  kind_ertn_reg;
    assign bus.ex_ecode       = ecode_reg;
    assign bus.ex_esubcode    = esubcode_reg;
    assign bus.ex_era         = era_reg;
    assign bus.ex_badv        = badv_reg;
    assign bus.busy           = (state_reg != ST_IDLE);
    assign bus.flush          = (state_reg != ST_IDLE) ? 4'hF : 4'h0;
    assign bus.redirect_valid = (state_reg == ST_REDIRECT);
    assign bus.redirect_pc    = redirect_pc_reg;

`ifdef EXC_FLUSH_CTRL_PERF_EN
    // Index 0: EX commits, 1: ERTN commits, 2: busy cycles.
    logic [2:0] perf_inc;
    assign perf_inc[0] = bus.ex_commit;
    assign perf_inc[1] = bus.ertn_commit;
    assign perf_inc[2] = bus.busy;

    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
        logic [31:0] cnt_reg;
        // Saturating event counter.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_reg <= 32'd0;
            end else if (perf_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
                cnt_reg <= cnt_reg + 32'd1;
            end
        end
    end

    assign perf_ex_cnt   = g_perf[0].cnt_reg;
    assign perf_ertn_cnt = g_perf[1].cnt_reg;
    assign perf_busy_cyc = g_perf[2].cnt_reg;
`endif

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// tb_exc_flush_ctrl: directed self-checking bench. dut_a runs with a
// two-cycle drain window, dut_b with no drain window.
module tb_exc_flush_ctrl;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_cmp = 0;
    int   n_bad = 0;

    exc_flush_ctrl_if bus_a();
    exc_flush_ctrl_if bus_b();

`ifdef EXC_FLUSH_CTRL_PERF_EN
    logic [31:0] pa_ex, pa_ertn, pa_busy;
    logic [31:0] pb_ex, pb_ertn, pb_busy;
`endif

    always #5 clk = ~clk;

    exc_flush_ctrl #(.DRAIN_CYCLES(2)) dut_a (
        .clk           (clk),
        .reset         (rst_a),
        .bus           (bus_a)
`ifdef EXC_FLUSH_CTRL_PERF_EN
        ,
        .perf_ex_cnt   (pa_ex),
        .perf_ertn_cnt (pa_ertn),
        .perf_busy_cyc (pa_busy)
`endif
    );

    exc_flush_ctrl #(.DRAIN_CYCLES(0)) dut_b (
        .clk           (clk),
        .reset         (rst_b),
        .bus           (bus_b)
`ifdef EXC_FLUSH_CTRL_PERF_EN
        ,
        .perf_ex_cnt   (pb_ex),
        .perf_ertn_cnt (pb_ertn),
        .perf_busy_cyc (pb_busy)
`endif
    );

    // Drop all request lines of dut_a (stimulus only).
    task automatic clear_req_a();
        bus_a.wb_ex      = 1'b0;
        bus_a.int_req    = 1'b0;
        bus_a.ertn_flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        clear_req_a();
        bus_a.wb_ecode = 6'd0;  bus_a.wb_esubcode = 9'd0;
        bus_a.wb_csr_pc = 32'd0; bus_a.wb_wrong_addr = 32'd0;
        bus_a.int_pc = 32'd0;   bus_a.csr_eentry = 32'd0;
        bus_a.csr_era = 32'd0;  bus_a.redirect_ready = 1'b1;
        bus_b.wb_ex = 1'b0;     bus_b.int_req = 1'b0; bus_b.ertn_flush = 1'b0;
        bus_b.wb_ecode = 6'd0;  bus_b.wb_esubcode = 9'd0;
        bus_b.wb_csr_pc = 32'd0; bus_b.wb_wrong_addr = 32'd0;
        bus_b.int_pc = 32'd0;   bus_b.csr_eentry = 32'd0;
        bus_b.csr_era = 32'd0;  bus_b.redirect_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus_a.ex_commit, bus_a.ertn_commit, bus_a.flush, bus_a.redirect_valid, bus_a.busy} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_ctrl_a got=%h exp=00", {bus_a.ex_commit, bus_a.ertn_commit, bus_a.flush, bus_a.redirect_valid, bus_a.busy});
        end
        n_cmp++;
        if ({bus_a.ex_ecode, bus_a.ex_esubcode, bus_a.ex_era, bus_a.ex_badv, bus_a.redirect_pc} !== '0) begin
            n_bad++;
            $display("FAIL reset_latch_a got=%h exp=0", {bus_a.ex_ecode, bus_a.ex_esubcode, bus_a.ex_era, bus_a.ex_badv, bus_a.redirect_pc});
        end
        n_cmp++;
        if ({bus_b.ex_commit, bus_b.ertn_commit, bus_b.flush, bus_b.redirect_valid, bus_b.busy} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_ctrl_b got=%h exp=00", {bus_b.ex_commit, bus_b.ertn_commit, bus_b.flush, bus_b.redirect_valid, bus_b.busy});
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        $display("[tb] reset transaction done");
    endtask

    task automatic test_exception();
        bus_a.wb_ex = 1'b1;       bus_a.wb_ecode = 6'h0B;  bus_a.wb_esubcode = 9'h005;
        bus_a.wb_csr_pc = 32'h1C00_0100; bus_a.wb_wrong_addr = 32'h0BAD_0AD0;
        bus_a.csr_eentry = 32'h1C00_8000; bus_a.redirect_ready = 1'b1;
        @(negedge clk);   // COMMIT
        clear_req_a();
        n_cmp++;
        if ({bus_a.ex_commit, bus_a.ertn_commit, bus_a.flush, bus_a.busy, bus_a.redirect_valid} !== 8'b10_1111_10) begin
            n_bad++;
            $display("FAIL ex_commit_ctrl got=%b exp=10111110", {bus_a.ex_commit, bus_a.ertn_commit, bus_a.flush, bus_a.busy, bus_a.redirect_valid});
        end
        n_cmp++;
        if ({bus_a.ex_ecode, bus_a.ex_esubcode, bus_a.ex_era, bus_a.ex_badv} !== {6'h0B, 9'h005, 32'h1C00_0100, 32'h0BAD_0AD0}) begin
            n_bad++;
            $display("FAIL ex_record got=%h/%h/%h/%h exp=0b/005/1c000100/0bad0ad0", bus_a.ex_ecode, bus_a.ex_esubcode, bus_a.ex_era, bus_a.ex_badv);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);   // DRAIN
            n_cmp++;
            if ({bus_a.ex_commit, bus_a.flush, bus_a.busy, bus_a.redirect_valid} !== 7'b0_1111_10) begin
                n_bad++;
                $display("FAIL ex_drain%0d got=%b exp=0111110", k, {bus_a.ex_commit, bus_a.flush, bus_a.busy, bus_a.redirect_valid});
            end
        end
        @(negedge clk);   // REDIRECT
        n_cmp++;
        if ({bus_a.redirect_valid, bus_a.flush, bus_a.redirect_pc} !== {1'b1, 4'hF, 32'h1C00_8000}) begin
            n_bad++;
            $display("FAIL ex_redirect got=%b/%h/%h exp=1/f/1c008000", bus_a.redirect_valid, bus_a.flush, bus_a.redirect_pc);
        end
        @(negedge clk);   // IDLE
        n_cmp++;
        if ({bus_a.busy, bus_a.flush, bus_a.redirect_valid} !== 6'b0) begin
            n_bad++;
            $display("FAIL ex_idle got=%b exp=000000", {bus_a.busy, bus_a.flush, bus_a.redirect_valid});
        end
        $display("[tb] EX transaction ecode=0b era=1c000100 -> 1c008000");
    endtask

    task automatic test_ertn();
        bus_a.csr_era = 32'h1C00_0104;
        bus_a.ertn_flush = 1'b1;
        @(negedge clk);   // COMMIT
        clear_req_a();
        n_cmp++;
        if ({bus_a.ex_commit, bus_a.ertn_commit, bus_a.flush} !== 6'b01_1111) begin
            n_bad++;
            $display("FAIL ertn_commit got=%b exp=011111", {bus_a.ex_commit, bus_a.ertn_commit, bus_a.flush});
        end
        n_cmp++;
        if (bus_a.ex_era !== 32'h1C00_0100) begin
            n_bad++;
            $display("FAIL ertn_era_kept got=%h exp=1c000100", bus_a.ex_era);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus_a.ex_commit, bus_a.ertn_commit, bus_a.redirect_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL ertn_drain got=%b exp=000", {bus_a.ex_commit, bus_a.ertn_commit, bus_a.redirect_valid});
        end
        @(negedge clk);   // REDIRECT
        n_cmp++;
        if ({bus_a.redirect_valid, bus_a.redirect_pc} !== {1'b1, 32'h1C00_0104}) begin
            n_bad++;
            $display("FAIL ertn_redirect got=%b/%h exp=1/1c000104", bus_a.redirect_valid, bus_a.redirect_pc);
        end
        @(negedge clk);
        n_cmp++;
        if (bus_a.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ertn_idle got=%b exp=0", bus_a.busy);
        end
        $display("[tb] ERTN transaction -> 1c000104");
    endtask

    task automatic test_simultaneous();
        bus_a.wb_ex = 1'b1; bus_a.ertn_flush = 1'b1;
        bus_a.wb_ecode = 6'h08; bus_a.wb_esubcode = 9'h000;
        bus_a.wb_csr_pc = 32'h1C00_0200; bus_a.wb_wrong_addr = 32'h0000_2000;
        @(negedge clk);   // COMMIT
        clear_req_a();
        n_cmp++;
        if ({bus_a.ex_commit, bus_a.ertn_commit, bus_a.ex_era} !== {2'b10, 32'h1C00_0200}) begin
            n_bad++;
            $display("FAIL sim_commit got=%b%b/%h exp=10/1c000200", bus_a.ex_commit, bus_a.ertn_commit, bus_a.ex_era);
        end
        @(negedge clk);   // DRAIN: a squashed exception arrives
        bus_a.wb_ex = 1'b1; bus_a.wb_ecode = 6'h0A; bus_a.wb_csr_pc = 32'h1C00_0300;
        @(negedge clk);
        clear_req_a();
        n_cmp++;
        if ({bus_a.ex_commit, bus_a.ex_ecode, bus_a.ex_era} !== {1'b0, 6'h08, 32'h1C00_0200}) begin
            n_bad++;
            $display("FAIL sim_ignore got=%b/%h/%h exp=0/08/1c000200", bus_a.ex_commit, bus_a.ex_ecode, bus_a.ex_era);
        end
        @(negedge clk);   // REDIRECT
        n_cmp++;
        if ({bus_a.redirect_valid, bus_a.redirect_pc} !== {1'b1, 32'h1C00_8000}) begin
            n_bad++;
            $display("FAIL sim_redirect got=%b/%h exp=1/1c008000", bus_a.redirect_valid, bus_a.redirect_pc);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus_a.busy, bus_a.ex_commit, bus_a.ertn_commit} !== 3'b000) begin
            n_bad++;
            $display("FAIL sim_no_second got=%b exp=000", {bus_a.busy, bus_a.ex_commit, bus_a.ertn_commit});
        end
        $display("[tb] EX+ERTN transaction -> exception only");
    endtask

    task automatic test_int_ready_low();
        bus_a.redirect_ready = 1'b0;
        bus_a.int_req = 1'b1; bus_a.int_pc = 32'h1C00_0400;
        bus_a.wb_wrong_addr = 32'hFFFF_0000; bus_a.wb_csr_pc = 32'h1C00_0BAD;
        @(negedge clk);   // COMMIT
        clear_req_a();
        n_cmp++;
        if ({bus_a.ex_commit, bus_a.ex_ecode, bus_a.ex_esubcode, bus_a.ex_era, bus_a.ex_badv} !==
            {1'b1, 6'h00, 9'h000, 32'h1C00_0400, 32'h0000_2000}) begin
            n_bad++;
            $display("FAIL int_record got=%b/%h/%h/%h/%h exp=1/00/000/1c000400/00002000",
                     bus_a.ex_commit, bus_a.ex_ecode, bus_a.ex_esubcode, bus_a.ex_era, bus_a.ex_badv);
        end
        repeat (3) @(negedge clk);   // REDIRECT entered
        bus_a.csr_eentry = 32'h1C00_9000;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            n_cmp++;
            if ({bus_a.redirect_valid, bus_a.flush, bus_a.busy, bus_a.redirect_pc} !== {1'b1, 4'hF, 1'b1, 32'h1C00_8000}) begin
                n_bad++;
                $display("FAIL hold%0d got=%b/%h/%b/%h exp=1/f/1/1c008000", k, bus_a.redirect_valid, bus_a.flush, bus_a.busy, bus_a.redirect_pc);
            end
        end
        bus_a.redirect_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus_a.busy, bus_a.redirect_valid, bus_a.flush} !== 6'b0) begin
            n_bad++;
            $display("FAIL hold_release got=%b exp=000000", {bus_a.busy, bus_a.redirect_valid, bus_a.flush});
        end
        bus_a.csr_eentry = 32'h1C00_8000;
        $display("[tb] INT transaction era=1c000400, ready low 5 cycles");
    endtask

    task automatic test_drain_zero();
        bus_b.csr_eentry = 32'h1C00_A000;
        bus_b.wb_ex = 1'b1; bus_b.wb_ecode = 6'h01; bus_b.wb_csr_pc = 32'h1C00_0500;
        @(negedge clk);   // COMMIT
        bus_b.wb_ex = 1'b0;
        n_cmp++;
        if ({bus_b.ex_commit, bus_b.redirect_valid, bus_b.flush} !== 6'b10_1111) begin
            n_bad++;
            $display("FAIL d0_commit got=%b exp=101111", {bus_b.ex_commit, bus_b.redirect_valid, bus_b.flush});
        end
        @(negedge clk);   // REDIRECT directly
        n_cmp++;
        if ({bus_b.ex_commit, bus_b.redirect_valid, bus_b.flush, bus_b.redirect_pc} !== {2'b01, 4'hF, 32'h1C00_A000}) begin
            n_bad++;
            $display("FAIL d0_redirect got=%b%b/%h/%h exp=01/f/1c00a000", bus_b.ex_commit, bus_b.redirect_valid, bus_b.flush, bus_b.redirect_pc);
        end
        @(negedge clk);
        n_cmp++;
        if (bus_b.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL d0_idle got=%b exp=0", bus_b.busy);
        end
        $display("[tb] EX transaction on zero-drain unit -> 1c00a000");
    endtask

    task automatic test_reset_mid();
        bus_a.wb_ex = 1'b1; bus_a.wb_ecode = 6'h02; bus_a.wb_csr_pc = 32'h1C00_0600;
        @(negedge clk);   // COMMIT
        clear_req_a();
        @(negedge clk);   // DRAIN
        n_cmp++;
        if ({bus_a.busy, bus_a.flush} !== 5'b1_1111) begin
            n_bad++;
            $display("FAIL rmid_pre got=%b exp=11111", {bus_a.busy, bus_a.flush});
        end
        #2 rst_a = 1'b1;
        #1;
        n_cmp++;
        if ({bus_a.ex_commit, bus_a.ertn_commit, bus_a.flush, bus_a.redirect_valid, bus_a.busy, bus_a.ex_era, bus_a.ex_ecode} !== '0) begin
            n_bad++;
            $display("FAIL rmid_async got=%b/%h/%h exp=0", {bus_a.ex_commit, bus_a.ertn_commit, bus_a.flush, bus_a.redirect_valid, bus_a.busy}, bus_a.ex_era, bus_a.ex_ecode);
        end
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        bus_a.csr_era = 32'h1C00_0700;
        bus_a.ertn_flush = 1'b1;
        @(negedge clk);   // COMMIT
        clear_req_a();
        n_cmp++;
        if ({bus_a.ex_commit, bus_a.ertn_commit} !== 2'b01) begin
            n_bad++;
            $display("FAIL rmid_after_commit got=%b exp=01", {bus_a.ex_commit, bus_a.ertn_commit});
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus_a.redirect_valid, bus_a.redirect_pc} !== {1'b1, 32'h1C00_0700}) begin
            n_bad++;
            $display("FAIL rmid_after_redirect got=%b/%h exp=1/1c000700", bus_a.redirect_valid, bus_a.redirect_pc);
        end
        @(negedge clk);
        $display("[tb] reset in DRAIN, then ERTN -> 1c000700");
    endtask

`ifdef EXC_FLUSH_CTRL_PERF_EN
    task automatic test_perf();
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        n_cmp++;
        if ({pa_ex, pa_ertn, pa_busy} !== 96'd0) begin
            n_bad++;
            $display("FAIL perf_reset got=%0d/%0d/%0d exp=0/0/0", pa_ex, pa_ertn, pa_busy);
        end
        bus_a.redirect_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) bus_a.wb_ex = 1'b1;
            else       bus_a.ertn_flush = 1'b1;
            @(negedge clk);
            clear_req_a();
            repeat (4) @(negedge clk);
        end
        n_cmp++;
        if ({pa_ex, pa_ertn, pa_busy} !== {32'd3, 32'd1, 32'd16}) begin
            n_bad++;
            $display("FAIL perf_counts got=%0d/%0d/%0d exp=3/1/16", pa_ex, pa_ertn, pa_busy);
        end
        $display("[tb] perf transaction ex=%0d ertn=%0d busy=%0d", pa_ex, pa_ertn, pa_busy);
    endtask
`endif

    initial begin
        test_reset();
        test_exception();
        test_ertn();
        test_simultaneous();
        test_int_ready_low();
        test_drain_zero();
        test_reset_mid();
`ifdef EXC_FLUSH_CTRL_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
